// File: rtl/psa_bus_pkg.sv
// Shared bus widths, command codes and FSM encoding for the Z80-style I/O master.
package psa_bus_pkg;
    localparam int ZA_W  = 8;
    localparam int ZD_W  = 8;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        CMD_RD  = 2'b00,
        CMD_WR  = 2'b01,
        CMD_RST = 2'b10,
        CMD_NOP = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_RLO  = 3'd5,
        ST_RREC = 3'd6
    } state_e;
endpackage

// File: rtl/z80_tstate_timer.sv
// Reloadable down-counter; tick marks the last clock of the current T-state or reset phase.
// Loading N yields a tick N cycles later, so a phase of L clocks is loaded with L-1.
module z80_tstate_timer
    import psa_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/z80_io_master.sv
// Z80-style I/O bus initiator: T1/T2/TW/T3 read/write cycles and nRST pulses from a valid/ready command.
// Optional responder wait handshake (i_nWAIT) is compiled in with the Z80_IO_WAIT_EN macro.
module z80_io_master
    import psa_bus_pkg::*;
#(
    parameter int TSTATE_CLKS = 2,
    parameter int WAIT_STATES = 1,
    parameter int RST_CLKS    = 4,
    parameter int RST_RECOVER = 4
) (
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_VALID,
    output logic            o_READY,
    input  logic [1:0]      i_CMD,
    input  logic [ZA_W-1:0] i_ADDR,
    input  logic [ZD_W-1:0] i_WDATA,
    output logic            o_DONE,
    output logic [ZD_W-1:0] o_RDATA,
    output logic [ZA_W-1:0] o_ZA,
    output logic [ZD_W-1:0] o_ZD,
    output logic            o_ZD_OE,
    input  logic [ZD_W-1:0] i_ZD,
    output logic            o_nIORQ,
    output logic            o_nRD,
    output logic            o_nWR,
`ifdef Z80_IO_WAIT_EN
    input  logic            i_nWAIT,
`endif
    output logic            o_nRST
);
    localparam logic [CNT_W-1:0] T_LOAD    = CNT_W'(TSTATE_CLKS - 1);
    localparam logic [CNT_W-1:0] RLO_LOAD  = CNT_W'(RST_CLKS - 1);
    localparam logic [CNT_W-1:0] RREC_LOAD = CNT_W'(RST_RECOVER - 1);
    localparam logic [3:0]       TW_MIN    = 4'(WAIT_STATES);

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [ZA_W-1:0] za_q, za_d;
    logic [ZD_W-1:0] zd_q, zd_d;
    logic [ZD_W-1:0] rdata_q, rdata_d;
    logic            done_q, done_d;
    logic [3:0]      tw_cnt_q, tw_cnt_d, tw_inc;
    logic            tmr_load, tmr_tick, nwait, strobe;
    logic [CNT_W-1:0] tmr_val;

`ifdef Z80_IO_WAIT_EN
    assign nwait = i_nWAIT;
`else
    assign nwait = 1'b1;
`endif

    z80_tstate_timer u_timer (
        .clk      (i_CLK),
        .rst      (i_RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_RD;
            za_q     <= '0;
            zd_q     <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            tw_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            za_q     <= za_d;
            zd_q     <= zd_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            tw_cnt_q <= tw_cnt_d;
        end
    end

    // Wait-state count saturates so long responder stalls cannot wrap it below the minimum.
    assign tw_inc = (tw_cnt_q == 4'hF) ? tw_cnt_q : tw_cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        za_d     = za_q;
        zd_d     = zd_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        tw_cnt_d = tw_cnt_q;
        tmr_load = 1'b0;
        tmr_val  = T_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (i_VALID) begin
                    cmd_d    = cmd_e'(i_CMD);
                    tmr_load = 1'b1;
                    case (cmd_e'(i_CMD))
                        CMD_RD, CMD_WR: begin
                            state_d = ST_T1;
                            za_d    = i_ADDR;
                            if (i_CMD == CMD_WR) zd_d = i_WDATA;
                        end
                        CMD_RST: begin
                            state_d = ST_RLO;
                            tmr_val = RLO_LOAD;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_T1: begin
                if (tmr_tick) begin
                    state_d  = ST_T2;
                    tmr_load = 1'b1;
                end
            end
            ST_T2: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    tw_cnt_d = '0;
                    state_d  = (TW_MIN == 4'd0 && nwait) ? ST_T3 : ST_TW;
                end
            end
            ST_TW: begin
                if (tmr_tick) begin
                    tmr_load = 1'b1;
                    tw_cnt_d = tw_inc;
                    if (tw_inc >= TW_MIN && nwait) state_d = ST_T3;
                end
            end
            ST_T3: begin
                if (tmr_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (cmd_q == CMD_RD) rdata_d = i_ZD;
                end
            end
            ST_RLO: begin
                if (tmr_tick) begin
                    if (RST_RECOVER == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_RREC;
                        tmr_load = 1'b1;
                        tmr_val  = RREC_LOAD;
                    end
                end
            end
            ST_RREC: begin
                if (tmr_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        strobe  = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
        o_READY = (state_q == ST_IDLE);
        o_nIORQ = !strobe;
        o_nRD   = !(strobe && cmd_q == CMD_RD);
        o_nWR   = !(strobe && cmd_q == CMD_WR);
        o_ZD_OE = (strobe || state_q == ST_T1) && cmd_q == CMD_WR;
        o_nRST  = (state_q != ST_RLO);
    end

    assign o_ZA    = za_q;
    assign o_ZD    = zd_q;
    assign o_RDATA = rdata_q;
    assign o_DONE  = done_q;
endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master with default parameters; cycle-by-cycle bus expectations.
module tb_z80_io_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_VALID;
    logic       o_READY;
    logic [1:0] i_CMD;
    logic [7:0] i_ADDR, i_WDATA, i_ZD;
    logic       o_DONE;
    logic [7:0] o_RDATA, o_ZA, o_ZD;
    logic       o_ZD_OE, o_nIORQ, o_nRD, o_nWR, o_nRST;
`ifdef Z80_IO_WAIT_EN
    logic       i_nWAIT;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] za_m, rdata_m;

    always #5 clk = ~clk;

    z80_io_master dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_CMD   (i_CMD),
        .i_ADDR  (i_ADDR),
        .i_WDATA (i_WDATA),
        .o_DONE  (o_DONE),
        .o_RDATA (o_RDATA),
        .o_ZA    (o_ZA),
        .o_ZD    (o_ZD),
        .o_ZD_OE (o_ZD_OE),
        .i_ZD    (i_ZD),
        .o_nIORQ (o_nIORQ),
        .o_nRD   (o_nRD),
        .o_nWR   (o_nWR),
`ifdef Z80_IO_WAIT_EN
        .i_nWAIT (i_nWAIT),
`endif
        .o_nRST  (o_nRST)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Enters and leaves on a falling edge where o_READY is expected high.
    task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] zd);
        int  lat;
        bit  io, strb;
        lat = (cmd == 2'b11) ? 1 : 9;
        io  = (cmd[1] == 1'b0);
        chk("accept_ready", 32'(o_READY), 32'd1);
        i_VALID = 1'b1; i_CMD = cmd; i_ADDR = addr; i_WDATA = wdata;
        @(posedge clk); #1;
        i_VALID = 1'b0; i_ADDR = 8'hEE; i_WDATA = 8'h11;
        if (io) za_m = addr;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            strb = io && k >= 3 && k <= 8;
            if (k == lat && cmd == 2'b00) rdata_m = zd;
            chk("nIORQ", 32'(o_nIORQ), 32'(!strb));
            chk("nRD",   32'(o_nRD),   32'(!(strb && cmd == 2'b00)));
            chk("nWR",   32'(o_nWR),   32'(!(strb && cmd == 2'b01)));
            chk("ZD_OE", 32'(o_ZD_OE), 32'(cmd == 2'b01 && k <= 8));
            if (cmd == 2'b01 && k <= 8) chk("ZD", 32'(o_ZD), 32'(wdata));
            chk("ZA",    32'(o_ZA),    32'(za_m));
            chk("nRST",  32'(o_nRST),  32'(!(cmd == 2'b10 && k <= 4)));
            chk("DONE",  32'(o_DONE),  32'(k == lat));
            chk("READY", 32'(o_READY), 32'(k == lat));
            chk("RDATA", 32'(o_RDATA), 32'(rdata_m));
            i_ZD = (k == 8) ? zd : 8'hC3;
        end
    endtask

    initial begin
        rst = 1'b1; i_VALID = 1'b0; i_CMD = 2'b00; i_ADDR = 8'h00;
        i_WDATA = 8'h00; i_ZD = 8'h00;
`ifdef Z80_IO_WAIT_EN
        i_nWAIT = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_READY), 32'd1);
        chk("rst_done",  32'(o_DONE),  32'd0);
        chk("rst_rdata", 32'(o_RDATA), 32'h00);
        chk("rst_za",    32'(o_ZA),    32'h00);
        chk("rst_zd",    32'(o_ZD),    32'h00);
        chk("rst_zd_oe", 32'(o_ZD_OE), 32'd0);
        chk("rst_strb",  32'({o_nIORQ, o_nRD, o_nWR}), 32'h7);
        chk("rst_nrst",  32'(o_nRST),  32'd1);
        rst = 1'b0; za_m = 8'h00; rdata_m = 8'h00;

        run_cmd(2'b01, 8'hA5, 8'h3C, 8'h00);
        run_cmd(2'b00, 8'h10, 8'h00, 8'h5A);
        run_cmd(2'b00, 8'h22, 8'h00, 8'h96);
        run_cmd(2'b11, 8'h77, 8'h00, 8'h00);
        run_cmd(2'b01, 8'h00, 8'hFF, 8'h00);
        for (int p = 0; p < 3; p++) run_cmd(2'b10, 8'h44, 8'h00, 8'h00);

        // Abort a write in its TW state with the synchronous reset.
        chk("abort_ready", 32'(o_READY), 32'd1);
        i_VALID = 1'b1; i_CMD = 2'b01; i_ADDR = 8'h5C; i_WDATA = 8'hE7;
        @(posedge clk); #1;
        i_VALID = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_tw_nwr", 32'(o_nWR), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strb",  32'({o_nIORQ, o_nRD, o_nWR}), 32'h7);
        chk("abort_zd_oe", 32'(o_ZD_OE), 32'd0);
        chk("abort_done",  32'(o_DONE),  32'd0);
        chk("abort_ready", 32'(o_READY), 32'd1);
        chk("abort_rdata", 32'(o_RDATA), 32'h00);
        chk("abort_za",    32'(o_ZA),    32'h00);
        rst = 1'b0; za_m = 8'h00; rdata_m = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(o_DONE), 32'd0);
        end
        run_cmd(2'b00, 8'h81, 8'h00, 8'h3D);
        run_cmd(2'b01, 8'h82, 8'h69, 8'h00);

`ifdef Z80_IO_WAIT_EN
        chk("wait_ready", 32'(o_READY), 32'd1);
        i_VALID = 1'b1; i_CMD = 2'b00; i_ADDR = 8'h3E;
        @(posedge clk); #1;
        i_VALID = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) rdata_m = 8'h77;
            chk("wait_nrd",   32'(o_nRD),   32'(!(k >= 3 && k <= 14)));
            chk("wait_done",  32'(o_DONE),  32'(k == 15));
            chk("wait_rdata", 32'(o_RDATA), 32'(rdata_m));
            i_nWAIT = !(k >= 5 && k <= 10);
            i_ZD    = (k == 14) ? 8'h77 : 8'hC3;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
